// File: rtl/mdio_rd_pkg.sv
// rtl/mdio_rd_pkg.sv - shared types and default sizes for the MDIO capture-memory read path
package mdio_rd_pkg;

    localparam int DEF_NUM_BANK = 24;
    localparam int DEF_LANES    = 4;
    localparam int DEF_LANE_W   = 9;
    localparam int DEF_ADDR_W   = 15;

    // Wide enough for RD_LAT up to 7
    localparam int LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPT
    } rd_state_e;

endpackage

// File: rtl/mdio_lane_mux.sv
// rtl/mdio_lane_mux.sv - combinational NUM_BANK x LANES lane selector over packed bank read data
module mdio_lane_mux
    import mdio_rd_pkg::*;
#(
    parameter int NUM_BANK = DEF_NUM_BANK,
    parameter int LANES    = DEF_LANES,
    parameter int LANE_W   = DEF_LANE_W,
    parameter int BANK_W   = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
    parameter int LSEL_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [BANK_W-1:0]                bank_i,
    input  logic [LSEL_W-1:0]                lane_i,
    input  logic [NUM_BANK*LANES*LANE_W-1:0] din_i,
    output logic [LANE_W-1:0]                lane_data_o
);

    always_comb begin
        lane_data_o = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int l = 0; l < LANES; l++) begin
                if (bank_i == BANK_W'(b) && lane_i == LSEL_W'(l)) begin
                    lane_data_o = din_i[(b*LANES+l)*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/mdio_mem_rd_ctrl.sv
// rtl/mdio_mem_rd_ctrl.sv - MDIO read controller for ADC capture banks; MDIO_RD_AUTOINC_EN adds pointer auto-increment
module mdio_mem_rd_ctrl
    import mdio_rd_pkg::*;
#(
    parameter int NUM_BANK = DEF_NUM_BANK,
    parameter int LANES    = DEF_LANES,
    parameter int LANE_W   = DEF_LANE_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = 1,
    parameter int SEL_W    = $clog2(NUM_BANK * LANES)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             rd_en,
    input  logic [SEL_W-1:0]                 cfg_lane_max,
    input  logic                             rd_req,
    input  logic [SEL_W-1:0]                 rd_lane_sel,
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic                             rd_autoinc,
    output logic [NUM_BANK-1:0]              mem_chip_en,
    output logic [NUM_BANK*ADDR_W-1:0]       mem_addr,
    input  logic [NUM_BANK*LANES*LANE_W-1:0] mem_din,
    output logic [LANE_W-1:0]                rd_data,
    output logic                             rd_data_vld,
    output logic                             rd_busy,
    output logic                             rd_err,
    output logic                             rd_done
);

    localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int NSEL   = NUM_BANK * LANES;

    rd_state_e                  state_q;
    logic [LAT_CNT_W-1:0]       cnt_q;
    logic [SEL_W-1:0]           sel_q, lmax_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [NUM_BANK-1:0]        chip_en_q;
    logic [NUM_BANK*ADDR_W-1:0] mem_addr_q;
    logic [LANE_W-1:0]          rd_data_q, lane_data;
    logic                       vld_q, err_q, done_q;

    logic [SEL_W-1:0]           req_sel;
    logic [ADDR_W-1:0]          req_addr;
    logic [BANK_W-1:0]          req_bank, cap_bank;
    logic [LSEL_W-1:0]          cap_lane;
    logic                       req_bad;

`ifdef MDIO_RD_AUTOINC_EN
    logic [SEL_W-1:0]  sel_ptr_q, sel_ptr_d;
    logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;

    // Pointer always advances one word past the captured request, walking lanes after the last word
    always_comb begin
        sel_ptr_d  = sel_q;
        addr_ptr_d = addr_q + ADDR_W'(1);
        if (&addr_q) begin
            sel_ptr_d = (sel_q >= lmax_q) ? '0 : sel_q + SEL_W'(1);
        end
    end

    assign req_sel  = rd_autoinc ? sel_ptr_q  : rd_lane_sel;
    assign req_addr = rd_autoinc ? addr_ptr_q : rd_addr;
`else
    logic unused_autoinc;
    assign unused_autoinc = rd_autoinc;
    assign req_sel        = rd_lane_sel;
    assign req_addr       = rd_addr;
`endif

    assign req_bad  = (int'(req_sel) >= NSEL) || (req_sel > cfg_lane_max);
    assign req_bank = BANK_W'(req_sel / SEL_W'(LANES));
    assign cap_bank = BANK_W'(sel_q / SEL_W'(LANES));
    assign cap_lane = LSEL_W'(sel_q % SEL_W'(LANES));

    mdio_lane_mux #(
        .NUM_BANK (NUM_BANK),
        .LANES    (LANES),
        .LANE_W   (LANE_W),
        .BANK_W   (BANK_W),
        .LSEL_W   (LSEL_W)
    ) u_lane_mux (
        .bank_i      (cap_bank),
        .lane_i      (cap_lane),
        .din_i       (mem_din),
        .lane_data_o (lane_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            lmax_q     <= '0;
            addr_q     <= '0;
            chip_en_q  <= '0;
            mem_addr_q <= '0;
            rd_data_q  <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef MDIO_RD_AUTOINC_EN
            sel_ptr_q  <= '0;
            addr_ptr_q <= '0;
`endif
        end else if (!rd_en) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            chip_en_q  <= '0;
            mem_addr_q <= '0;
            rd_data_q  <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef MDIO_RD_AUTOINC_EN
            sel_ptr_q  <= '0;
            addr_ptr_q <= '0;
`endif
        end else begin
            chip_en_q  <= '0;
            mem_addr_q <= '0;
            vld_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_req) begin
                        sel_q  <= req_sel;
                        addr_q <= req_addr;
                        lmax_q <= cfg_lane_max;
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= ST_ISSUE;
                            for (int b = 0; b < NUM_BANK; b++) begin
                                chip_en_q[b] <= (req_bank == BANK_W'(b));
                                mem_addr_q[b*ADDR_W +: ADDR_W] <=
                                    (req_bank == BANK_W'(b)) ? req_addr : '0;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (RD_LAT == 1) begin
                        state_q <= ST_CAPT;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= LAT_CNT_W'(RD_LAT - 2);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_q <= ST_CAPT;
                    else             cnt_q   <= cnt_q - LAT_CNT_W'(1);
                end
                ST_CAPT: begin
                    rd_data_q <= lane_data;
                    vld_q     <= 1'b1;
                    state_q   <= ST_IDLE;
                    if (sel_q == lmax_q && &addr_q) done_q <= 1'b1;
`ifdef MDIO_RD_AUTOINC_EN
                    sel_ptr_q  <= sel_ptr_d;
                    addr_ptr_q <= addr_ptr_d;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_chip_en = chip_en_q;
    assign mem_addr    = mem_addr_q;
    assign rd_data     = rd_data_q;
    assign rd_data_vld = vld_q;
    assign rd_busy     = (state_q != ST_IDLE);
    assign rd_err      = err_q;
    assign rd_done     = done_q;

endmodule
